// File: rtl/axis_out_serializer.sv
// Wide-to-narrow AXI-Stream serializer: each wide beat of NUM_CORES lanes is
// emitted lane 0 first as NUM_CORES narrow beats, with a frame counter on tlast.
module axis_out_serializer #(
  parameter int WIDTH      = 16,
  parameter int CHUNK_SIZE = 4,
  parameter int NUM_CORES  = 2
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0]  s_axis_tdata,
  input  logic                                   s_axis_tvalid,
  input  logic                                   s_axis_tlast,
  output logic                                   s_axis_tready,
  output logic [WIDTH*CHUNK_SIZE-1:0]            m_axis_tdata,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  input  logic                                   m_axis_tready,
  output logic [15:0]                            frame_cnt,
  output logic                                   busy
);

  localparam int LW     = WIDTH * CHUNK_SIZE;
  localparam int LANE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_CORES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [LW*NUM_CORES-1:0]  hold_q, hold_d;
  logic                     last_q, last_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;

  logic at_last;
  logic s_hs;
  logic m_hs;

  // Both ports use plain AXIS valid/ready: a beat transfers on a rising edge
  // where valid and ready are both 1; a raised valid is never retracted and
  // its payload stays stable until that edge.
  assign at_last = (lane_q == LAST_LANE);
  assign s_hs    = s_axis_tvalid && s_axis_tready;
  assign m_hs    = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (s_hs) state_d = S_SEND;
      S_SEND:  if (m_hs && at_last && !s_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags are forced low while reset is asserted, even mid-frame.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    busy          = 1'b0;
    if (!areset) begin
      case (state_q)
        S_IDLE: s_axis_tready = 1'b1;
        S_SEND: begin
          s_axis_tready = at_last && m_axis_tready;
          m_axis_tvalid = 1'b1;
          m_axis_tlast  = last_q && at_last;
          busy          = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (lane_q == LANE_W'(k)) m_axis_tdata = hold_q[k*LW +: LW];
    end
  end

  always_comb begin
    lane_d      = lane_q;
    hold_d      = hold_q;
    last_d      = last_q;
    frame_cnt_d = frame_cnt_q;
    if (s_hs) begin
      lane_d = '0;
      hold_d = s_axis_tdata;
      last_d = s_axis_tlast;
    end else if (m_hs && !at_last) begin
      lane_d = lane_q + LANE_W'(1);
    end
    if (m_hs && m_axis_tlast) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      lane_q      <= '0;
      hold_q      <= '0;
      last_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      lane_q      <= lane_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_axis_out_serializer.sv
// Directed bench for axis_out_serializer: a two-lane instance and a one-lane
// instance share clock and reset; each scenario task checks its own results.
module tb_axis_out_serializer;

  localparam int LW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            areset;

  logic [2*LW-1:0] s_tdata;
  logic            s_tvalid, s_tlast, s_tready;
  logic [LW-1:0]   m_tdata;
  logic            m_tvalid, m_tlast, m_tready;
  logic [15:0]     frame_cnt;
  logic            busy;

  logic [LW-1:0]   s1_tdata;
  logic            s1_tvalid, s1_tlast, s1_tready;
  logic [LW-1:0]   m1_tdata;
  logic            m1_tvalid, m1_tlast, m1_tready;
  logic [15:0]     frame_cnt1;
  logic            busy1;

  axis_out_serializer #(.WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(2)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  axis_out_serializer #(.WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(1)) dut1 (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tlast(s1_tlast),
    .s_axis_tready(s1_tready),
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tlast(m1_tlast),
    .m_axis_tready(m1_tready),
    .frame_cnt(frame_cnt1), .busy(busy1)
  );

  int passed = 0;
  int total  = 0;

  logic [LW:0]     exp_q[$];
  logic [LW:0]     obs_q[$];
  logic [2*LW-1:0] in_data[4];
  int              stab_err;
  logic [31:0]     srdy_mask;
  int              first_v, last_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0; m1_tready = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  // Expected narrow beats {tlast, data}: lane 0 first, tlast on the last lane of the last beat.
  task automatic build_exp(input int nbeats);
    exp_q.delete();
    for (int b = 0; b < nbeats; b++) begin
      exp_q.push_back({1'b0, in_data[b][LW-1:0]});
      exp_q.push_back({(b == nbeats - 1), in_data[b][2*LW-1:LW]});
    end
  endtask

  // Drives nbeats wide beats into the two-lane instance and records what comes out.
  task automatic run_stream(input int nbeats, input int stall_pct);
    int sent = 0;
    int cyc = 0;
    logic stall_prev = 1'b0;
    logic [LW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    obs_q.delete();
    stab_err = 0; srdy_mask = '0; first_v = -1; last_v = -1;
    while ((sent < nbeats || obs_q.size() < 2*nbeats) && cyc < 200) begin
      s_tvalid = (sent < nbeats);
      if (sent < nbeats) s_tdata = in_data[sent];
      else               s_tdata = '0;
      s_tlast  = (sent == nbeats - 1);
      m_tready = ($urandom_range(99) >= stall_pct);
      #1;
      if (stall_prev && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
        stab_err++;
      if (m_tvalid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (m_tvalid === 1'b1 && m_tready) obs_q.push_back({m_tlast, m_tdata});
      if (cyc < 32 && s_tready === 1'b1) srdy_mask[cyc] = 1'b1;
      stall_prev = (m_tvalid === 1'b1) && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (s_tvalid && s_tready === 1'b1) sent++;
      tick();
      cyc++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
  endtask

  task automatic test_reset();
    areset = 1'b1; s_tvalid = 1'b1; s_tdata = '1; s_tlast = 1'b1; m_tready = 1'b1;
    s1_tvalid = 1'b1; s1_tdata = '1; s1_tlast = 1'b1; m1_tready = 1'b1;
    tick(); tick();
    total++; if (s_tready !== 1'b0) begin $display("FAIL reset_s_tready got %b want 0", s_tready); end else passed++;
    total++; if (m_tvalid !== 1'b0) begin $display("FAIL reset_m_tvalid got %b want 0", m_tvalid); end else passed++;
    total++; if (m_tlast !== 1'b0) begin $display("FAIL reset_m_tlast got %b want 0", m_tlast); end else passed++;
    total++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); end else passed++;
    total++; if (frame_cnt !== 16'd0) begin $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end else passed++;
    total++; if (s1_tready !== 1'b0 || m1_tvalid !== 1'b0) begin $display("FAIL reset_nc1_flags got %b%b want 00", s1_tready, m1_tvalid); end else passed++;
    areset = 1'b0; s_tvalid = 1'b0; s1_tvalid = 1'b0;
    tick();
    total++; if (s_tready !== 1'b1) begin $display("FAIL post_reset_s_tready got %b want 1", s_tready); end else passed++;
    total++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin $display("FAIL post_reset_idle got busy=%b valid=%b want 0 0", busy, m_tvalid); end else passed++;
  endtask

  task automatic test_single_beat();
    do_reset();
    s_tvalid = 1'b1; s_tlast = 1'b1; m_tready = 1'b1;
    s_tdata = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    #1;
    total++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin $display("FAIL s1_load got ready=%b valid=%b want 1 0", s_tready, m_tvalid); end else passed++;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h2222_2222_2222_2222 || m_tlast !== 1'b0)
      begin $display("FAIL s1_lane0 got v=%b d=%h l=%b want 1 2222222222222222 0", m_tvalid, m_tdata, m_tlast); end else passed++;
    total++; if (s_tready !== 1'b0) begin $display("FAIL s1_lane0_ready got %b want 0", s_tready); end else passed++;
    tick();
    total++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h1111_1111_1111_1111 || m_tlast !== 1'b1)
      begin $display("FAIL s1_lane1 got v=%b d=%h l=%b want 1 1111111111111111 1", m_tvalid, m_tdata, m_tlast); end else passed++;
    total++; if (s_tready !== 1'b1) begin $display("FAIL s1_lane1_ready got %b want 1", s_tready); end else passed++;
    tick();
    total++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin $display("FAIL s1_idle got valid=%b busy=%b want 0 0", m_tvalid, busy); end else passed++;
    total++; if (frame_cnt !== 16'd1) begin $display("FAIL s1_frame_cnt got %0d want 1", frame_cnt); end else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++)
      in_data[i] = {64'h1000_0000_0000_00B0 + 64'(i), 64'h2000_0000_0000_00A0 + 64'(i)};
    build_exp(4);
    run_stream(4, 0);
    total++; if (obs_q.size() !== 8) begin $display("FAIL b2b_count got %0d want 8", obs_q.size()); end else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= obs_q.size()) $display("FAIL b2b_beat%0d got none want %h", i, exp_q[i]);
      else if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++; if (first_v !== 1 || last_v !== 8) begin $display("FAIL b2b_window got %0d..%0d want 1..8", first_v, last_v); end else passed++;
    total++; if (srdy_mask !== 32'h155) begin $display("FAIL b2b_s_tready_pattern got %h want 155", srdy_mask); end else passed++;
    total++; if (frame_cnt !== 16'd1) begin $display("FAIL b2b_frame_cnt got %0d want 1", frame_cnt); end else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    run_stream(4, 30);
    total++; if (obs_q.size() !== 8) begin $display("FAIL stall_count got %0d want 8", obs_q.size()); end else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= obs_q.size()) $display("FAIL stall_beat%0d got none want %h", i, exp_q[i]);
      else if (obs_q[i] !== exp_q[i]) $display("FAIL stall_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++; if (stab_err !== 0) begin $display("FAIL stall_stability got %0d unstable cycles want 0", stab_err); end else passed++;
    total++; if (frame_cnt !== 16'd1) begin $display("FAIL stall_frame_cnt got %0d want 1", frame_cnt); end else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int vcnt = 0;
    do_reset();
    s_tvalid = 1'b1; s_tlast = 1'b1; m_tready = 1'b1;
    s_tdata = {64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002};
    #1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b1 || m_tdata !== 64'hCAFE_F00D_0000_0002) begin $display("FAIL rst_mid_first got v=%b d=%h want 1 cafef00d00000002", m_tvalid, m_tdata); end else passed++;
    tick();
    areset = 1'b1;
    #1;
    total++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || busy !== 1'b0) begin $display("FAIL rst_mid_during got v=%b r=%b b=%b want 0 0 0", m_tvalid, s_tready, busy); end else passed++;
    tick();
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (m_tvalid !== 1'b0) vcnt++;
      tick();
    end
    total++; if (vcnt !== 0) begin $display("FAIL rst_mid_residual got %0d valid cycles want 0", vcnt); end else passed++;
    total++; if (frame_cnt !== 16'd0) begin $display("FAIL rst_mid_frame_cnt got %0d want 0", frame_cnt); end else passed++;
    in_data[0] = {64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
    build_exp(1);
    run_stream(1, 0);
    total++; if (obs_q.size() !== 2) begin $display("FAIL rst_mid_new_count got %0d want 2", obs_q.size()); end else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= obs_q.size()) $display("FAIL rst_mid_new_beat%0d got none want %h", i, exp_q[i]);
      else if (obs_q[i] !== exp_q[i]) $display("FAIL rst_mid_new_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++; if (frame_cnt !== 16'd1) begin $display("FAIL rst_mid_new_frame_cnt got %0d want 1", frame_cnt); end else passed++;
  endtask

  task automatic test_nc1();
    do_reset();
    s1_tvalid = 1'b1; s1_tlast = 1'b0; s1_tdata = 64'hAAAA_0000_0000_0001; m1_tready = 1'b1;
    #1;
    total++; if (m1_tvalid !== 1'b0 || s1_tready !== 1'b1) begin $display("FAIL nc1_c0 got v=%b r=%b want 0 1", m1_tvalid, s1_tready); end else passed++;
    tick();
    s1_tdata = 64'hBBBB_0000_0000_0002;
    #1;
    total++; if (m1_tvalid !== 1'b1 || m1_tdata !== 64'hAAAA_0000_0000_0001 || m1_tlast !== 1'b0)
      begin $display("FAIL nc1_beat0 got v=%b d=%h l=%b want 1 aaaa000000000001 0", m1_tvalid, m1_tdata, m1_tlast); end else passed++;
    total++; if (s1_tready !== 1'b1) begin $display("FAIL nc1_reload_ready got %b want 1", s1_tready); end else passed++;
    tick();
    s1_tdata = 64'hCCCC_0000_0000_0003; s1_tlast = 1'b1;
    #1;
    total++; if (m1_tvalid !== 1'b1 || m1_tdata !== 64'hBBBB_0000_0000_0002 || m1_tlast !== 1'b0)
      begin $display("FAIL nc1_beat1 got v=%b d=%h l=%b want 1 bbbb000000000002 0", m1_tvalid, m1_tdata, m1_tlast); end else passed++;
    tick();
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    #1;
    total++; if (m1_tvalid !== 1'b1 || m1_tdata !== 64'hCCCC_0000_0000_0003 || m1_tlast !== 1'b1)
      begin $display("FAIL nc1_beat2 got v=%b d=%h l=%b want 1 cccc000000000003 1", m1_tvalid, m1_tdata, m1_tlast); end else passed++;
    tick();
    total++; if (m1_tvalid !== 1'b0 || busy1 !== 1'b0) begin $display("FAIL nc1_idle got v=%b b=%b want 0 0", m1_tvalid, busy1); end else passed++;
    total++; if (frame_cnt1 !== 16'd1) begin $display("FAIL nc1_frame_cnt got %0d want 1", frame_cnt1); end else passed++;
  endtask

  task automatic test_wrap();
    int cyc = 0;
    do_reset();
    s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 64'h0123_4567_89AB_CDEF; m1_tready = 1'b1;
    while (frame_cnt1 !== 16'hFFFF && cyc < 70000) begin
      tick();
      cyc++;
    end
    total++; if (frame_cnt1 !== 16'hFFFF) begin $display("FAIL wrap_preload got %h want ffff", frame_cnt1); end else passed++;
    total++; if (cyc !== 65536) begin $display("FAIL wrap_preload_cycles got %0d want 65536", cyc); end else passed++;
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    tick();
    total++; if (frame_cnt1 !== 16'h0000) begin $display("FAIL wrap_rollover got %h want 0000", frame_cnt1); end else passed++;
    total++; if (m1_tvalid !== 1'b0) begin $display("FAIL wrap_idle got %b want 0", m1_tvalid); end else passed++;
  endtask

  initial begin
    areset = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0; m1_tready = 1'b1;
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_stall();
    test_reset_mid_frame();
    test_nc1();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axis_out_serializer.md
AXIS_OUT_SERIALIZER -- requirements
Module: axis_out_serializer

Interface
- REQ-001: Parameter WIDTH, default 16: bits per fixed-point element.
- REQ-002: Parameter CHUNK_SIZE, default 4: elements per lane, giving lane width LW = WIDTH*CHUNK_SIZE = 64.
- REQ-003: Parameter NUM_CORES, default 2: lanes per wide input beat, legal range 1..17.
- REQ-004: Port aclk, input, 1 bit: single clock; all logic is on its rising edge.
- REQ-005: Port areset, input, 1 bit: reset, synchronous and active-high.
- REQ-006: Port s_axis_tdata, input, LW*NUM_CORES bits: wide result beat from the matrix-multiply output FIFO; lane k is bits [k*LW +: LW].
- REQ-007: Port s_axis_tvalid, input, 1 bit: wide beat valid.
- REQ-008: Port s_axis_tlast, input, 1 bit: wide beat ends a frame.
- REQ-009: Port s_axis_tready, output, 1 bit: block accepts a wide beat.
- REQ-010: Port m_axis_tdata, output, LW bits: narrow beat to the DMA S2MM.
- REQ-011: Port m_axis_tvalid, output, 1 bit: narrow beat valid.
- REQ-012: Port m_axis_tlast, output, 1 bit: narrow beat ends a frame.
- REQ-013: Port m_axis_tready, input, 1 bit: DMA accepts a narrow beat.
- REQ-014: Port frame_cnt, output, 16 bits: count of frames emitted.
- REQ-015: Port busy, output, 1 bit: high while a wide beat is held.

Function
- REQ-016: The block SHALL implement two states: IDLE (holding register empty) and SEND (holding register full).
- REQ-017: A wide-beat handshake SHALL occur on any rising edge with s_axis_tvalid=1 and s_axis_tready=1; on that edge the block SHALL capture tdata into the holding register, capture tlast into last_q, clear lane counter lane_q to 0, and enter or stay in SEND.
- REQ-018: In IDLE, s_axis_tready SHALL be 1.
- REQ-019: In SEND, s_axis_tready SHALL be 1 only when lane_q==NUM_CORES-1 and m_axis_tready==1; this is a combinational path that gives zero-bubble back-to-back wide beats. In every other SEND cycle it SHALL be 0.
- REQ-020: m_axis_tvalid SHALL equal (state==SEND).
- REQ-021: m_axis_tdata SHALL be lane lane_q of the holding register, so lane 0 (LSBs) goes out first.
- REQ-022: m_axis_tlast SHALL equal last_q AND (lane_q==NUM_CORES-1).
- REQ-023: A narrow-beat handshake (m_axis_tvalid AND m_axis_tready) with lane_q<NUM_CORES-1 SHALL increment lane_q.
- REQ-024: A narrow-beat handshake with lane_q==NUM_CORES-1 SHALL either reload per REQ-017, if s_axis_tvalid=1, or return to IDLE.
- REQ-025: While m_axis_tready=0, m_axis_tdata, m_axis_tvalid and m_axis_tlast SHALL be held stable (AXIS no-retract rule).
- REQ-026: Latency from a wide handshake to the first narrow beat valid SHALL be 1 cycle.
- REQ-027: With m_axis_tready held at 1, throughput SHALL be one narrow beat per cycle.
- REQ-028: frame_cnt SHALL increment by 1 on every narrow handshake with m_axis_tlast=1, and SHALL wrap from 0xFFFF to 0.
- REQ-029: busy SHALL equal (state==SEND).
- REQ-030: With NUM_CORES=1, the block SHALL act as a one-deep register slice: lane_q is constant 0, and m_axis_tlast equals last_q.
- REQ-031: lane_q width SHALL be max(1, clog2(NUM_CORES)) and SHALL never exceed NUM_CORES-1.

Reset
- REQ-032: When areset=1 at a rising edge, the block SHALL set state=IDLE, lane_q=0, last_q=0, holding register=0 and frame_cnt=0.
- REQ-033: During reset, m_axis_tvalid, m_axis_tlast and busy SHALL be 0 and s_axis_tready SHALL be 0.
- REQ-034: Reset asserted mid-frame SHALL discard any held beat, and SHALL leave no partial-beat emission after it deasserts.
- REQ-035: In the first cycle after areset deasserts, s_axis_tready SHALL be 1.

Verification
- REQ-036: Scenario 1: NUM_CORES=2, one wide beat 0x1111..._2222... with tlast=1, m_axis_tready=1 -> narrow beats 0x2222... then 0x1111... on consecutive cycles, tlast only on the second, frame_cnt=1.
- REQ-037: Scenario 2: 4 back-to-back wide beats, tlast on the 4th, m_axis_tready=1 -> 8 contiguous narrow beats with no bubble, s_axis_tready high every 2nd cycle, one tlast, frame_cnt=1.
- REQ-038: Scenario 3: random m_axis_tready with 30% stall -> data, valid and last stable across every stall, and output sequence identical to scenario 2.
- REQ-039: Scenario 4: areset pulsed after the first narrow beat of a frame -> no further m_axis_tvalid, frame_cnt=0, and a new frame after reset is emitted intact.
- REQ-040: Scenario 5: preload frame_cnt to 0xFFFF via 65535 one-beat frames, then one more frame -> frame_cnt=0.
- REQ-041: Scenario 6: NUM_CORES=1, 3 beats with tlast on the 3rd -> 3 output beats equal to input, 1-cycle latency, tlast on the 3rd.
